glb_read_dma: RTL and testbench
===============================

// Module: glb_read_dma
// PURPOSE
//  Streams a byte range out of the GLB to a consumer (PE-array input or output-writeback path).
//  - Takes a start command: base byte address plus length.
//  - Drives the GLB read port with re = 0001/0011/0111/1111.
//  - Captures the GLB's registered 32-bit dout into a small credit-controlled FIFO.
//  - Presents data as a valid/ready stream with byte-keep and last. The GLB cannot stall, so
//    read issue is throttled so that returned data always has a free FIFO slot.
// PARAMETERS
//  ADDR_WIDTH  32  GLB byte-address width (matches GLB r_addr)
//  LEN_WIDTH   16  width of byte-length field
//  FIFO_DEPTH  4   output FIFO entries (>=2, power of 2)
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           reset, asynchronous, active-low
//  start       in   1           command strobe; accepted only in IDLE
//  base_addr   in   ADDR_WIDTH  first byte address of transfer
//  byte_len    in   LEN_WIDTH   number of bytes to transfer (0 allowed)
//  busy        out  1           high from the cycle after start is accepted until done
//  done        out  1           1-cycle pulse when the transfer is complete
//  glb_re      out  4           GLB read enable (0000 / 0001 / 0011 / 0111 / 1111)
//  glb_r_addr  out  ADDR_WIDTH  GLB read byte address
//  glb_dout    in   32          GLB read data, valid the cycle after glb_re != 0
//  out_valid   out  1           stream beat valid
//  out_ready   in   1           consumer ready
//  out_data    out  32          beat data, byte 0 = lowest address in [7:0]
//  out_keep    out  4           valid bytes of beat (0001/0011/0111/1111)
//  out_last    out  1           final beat of transfer
// BEHAVIOUR
//  Reset: state=IDLE; FIFO empty; all outputs 0 (busy, done, glb_re, glb_r_addr, out_*).
//  FSM:
//   - IDLE -> RUN on start (latch base_addr, byte_len into addr, rem).
//   - In IDLE with start and byte_len==0: no read issued, no beat produced; done pulses the
//     next cycle; state stays IDLE.
//   - RUN -> DRAIN when the read that takes rem to 0 is issued.
//   - DRAIN -> IDLE when FIFO is empty, pending==0 and the last beat has been handshaken.
//     done pulses in the cycle after that handshake.
//   - start while busy is ignored.
//  Issue (RUN only), registered outputs:
//   - Issue when rem!=0 and fifo_count+pending < FIFO_DEPTH.
//   - pending = reads issued whose data is not yet written into the FIFO (0..2).
//   - A same-cycle pop is NOT counted as free space (conservative).
//   - Per issue: glb_r_addr=addr; glb_re = 1111 if rem>=4, else the rem-byte pattern.
//   - Then addr += 4 (wraps mod 2^ADDR_WIDTH) and rem -= min(rem,4).
//   - glb_re = 0000 in every cycle with no issue; glb_r_addr holds its last value.
//  Capture:
//   - For each issued read, glb_dout is sampled on the edge ending the cycle after issue
//     and pushed with keep = that read's re pattern.
//   - last = 1 on the push that carries the read which took rem to 0.
//   - glb_dout in non-capture cycles is ignored (the GLB drives 0 there).
//  Latency: start in cycle 0 -> glb_re!=0 in cycle 1 -> glb_dout in cycle 2 -> out_valid in
//   cycle 3. With out_ready=1 throughout, one beat per cycle is sustained.
//  Stream rules:
//   - out_data/out_keep/out_last are stable while out_valid && !out_ready.
//   - Beat transfers when out_valid && out_ready.
//   - Push and pop in the same cycle are both performed.
//   - The FIFO never overflows by construction; overflow is an assertion failure.
//  Reset mid-transfer: everything returns to reset values immediately; FIFO contents discarded.
// TESTING
//  1 base=0x100, len=8, ready=1 -> re=1111 @0x100 then @0x104; beats 2, keep 1111/1111, last on beat 2, done 1 cycle later.
//  2 base=0x200, len=7 -> re 1111 @0x200, 0111 @0x204; 2nd beat keep=0111, data[31:24]=0, last=1.
//  3 len=0 -> done pulse in cycle 1, glb_re stays 0000, out_valid never asserts.
//  4 len=64, out_ready=0 for 20 cycles then 1 -> issued reads plateau at FIFO_DEPTH; all 16 beats in order, none lost/duplicated.
//  5 start pulsed again mid-transfer -> ignored; only the original transfer's beats and one done.
//  6 rst_n low during RUN with 2 beats in FIFO -> outputs 0 immediately; a new start after release behaves as test 1.

Source files
------------

// File: rtl/glb_read_dma_if.sv
// Bundle of the command, GLB read-port and output-stream signals of glb_read_dma.
// master = the DMA itself; slave = the surrounding system (command source, GLB, consumer).
interface glb_read_dma_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  byte_len;
    logic                  busy;
    logic                  done;
    logic [3:0]            glb_re;
    logic [ADDR_WIDTH-1:0] glb_r_addr;
    logic [31:0]           glb_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic [3:0]            out_keep;
    logic                  out_last;

    modport master (
        input  start, base_addr, byte_len, glb_dout, out_ready,
        output busy, done, glb_re, glb_r_addr, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        output start, base_addr, byte_len, glb_dout, out_ready,
        input  busy, done, glb_re, glb_r_addr, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/glb_read_dma.sv
// Streams a byte range out of the GLB as a valid/ready stream with keep/last.
// Reads are only issued when the FIFO is guaranteed a free slot for the returning word.
module glb_read_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    glb_read_dma_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [3:0]            glb_re_q, glb_re_d;
    logic [ADDR_WIDTH-1:0] glb_r_addr_q, glb_r_addr_d;
    logic                  re_last_q, re_last_d;
    logic                  cap_vld_q;
    logic [3:0]            cap_keep_q;
    logic                  cap_last_q;
    logic                  done_q, done_d;

    logic [31:0]           mem_data_q [FIFO_DEPTH];
    logic [3:0]            mem_keep_q [FIFO_DEPTH];
    logic                  mem_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  push, pop, out_valid_w, out_last_w;
    logic [1:0]            pend;
    logic [CNT_W:0]        occ;
    logic                  iss, iss_last;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [LEN_WIDTH-1:0]  iss_rem;

    function automatic logic [3:0] re_pattern(input logic [LEN_WIDTH-1:0] r);
        if (r >= LEN_WIDTH'(4)) return 4'b1111;
        case (r[1:0])
            2'd3:    return 4'b0111;
            2'd2:    return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    // Reads in flight count as occupied; a same-cycle pop is deliberately not credited.
    assign pend = {1'b0, |glb_re_q} + {1'b0, cap_vld_q};
    assign occ  = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, pend};

    assign push        = cap_vld_q;
    assign out_valid_w = (count_q != '0);
    assign out_last_w  = out_valid_w & mem_last_q[rd_ptr_q];
    assign pop         = out_valid_w & bus.out_ready;

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        iss      = 1'b0;
        iss_addr = addr_q;
        iss_rem  = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.byte_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        iss      = 1'b1;
                        iss_addr = bus.base_addr;
                        iss_rem  = bus.byte_len;
                    end
                end
            end
            RUN:   iss = (rem_q != '0) && (occ < {1'b0, DEPTH_C});
            DRAIN: begin
                if (pop && out_last_w) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        iss_last = (iss_rem <= LEN_WIDTH'(4));
        if (iss) state_d = iss_last ? DRAIN : RUN;

        addr_d       = iss ? iss_addr + ADDR_WIDTH'(4) : addr_q;
        rem_d        = iss ? (iss_last ? '0 : iss_rem - LEN_WIDTH'(4)) : rem_q;
        glb_re_d     = iss ? re_pattern(iss_rem) : 4'b0000;
        glb_r_addr_d = iss ? iss_addr : glb_r_addr_q;
        re_last_d    = iss & iss_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            glb_re_q     <= '0;
            glb_r_addr_q <= '0;
            re_last_q    <= 1'b0;
            cap_vld_q    <= 1'b0;
            cap_keep_q   <= '0;
            cap_last_q   <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            glb_re_q     <= glb_re_d;
            glb_r_addr_q <= glb_r_addr_d;
            re_last_q    <= re_last_d;
            // GLB returns data one cycle after the read; this stage marks that cycle.
            cap_vld_q    <= |glb_re_q;
            cap_keep_q   <= glb_re_q;
            cap_last_q   <= re_last_q;
            done_q       <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        rem_q  <= rem_d;
        if (push) begin
            mem_data_q[wr_ptr_q] <= bus.glb_dout;
            mem_keep_q[wr_ptr_q] <= cap_keep_q;
            mem_last_q[wr_ptr_q] <= cap_last_q;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count_q == DEPTH_C));

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.glb_re     = glb_re_q;
    assign bus.glb_r_addr = glb_r_addr_q;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_data   = out_valid_w ? mem_data_q[rd_ptr_q] : '0;
    assign bus.out_keep   = out_valid_w ? mem_keep_q[rd_ptr_q] : '0;
    assign bus.out_last   = out_last_w;
endmodule

// File: tb/tb_glb_read_dma.sv
// Self-checking bench for glb_read_dma: GLB memory model, beat scoreboard, vector table
// and hand-written sequences for latency, zero length, backpressure, re-start and reset.
module tb_glb_read_dma;
    logic clk;
    logic rst_n;

    glb_read_dma_if #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) bus ();

    glb_read_dma #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        bit          rnd;
        int          exp_beats;
        logic [3:0]  exp_first_re;
        logic [3:0]  exp_last_keep;
    } vec_t;

    beat_t sb[$];
    int n_pass, n_total;
    int cyc, done_cnt, done_cyc, iss_cnt, beats, last_hs_cyc;
    logic [3:0] last_keep;
    logic [3:0] g_re;
    logic [31:0] g_addr, g_word;
    beat_t m_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // GLB model: registered read, disabled byte lanes and idle cycles return 0.
    initial begin
        bus.glb_dout = '0;
        forever begin
            @(posedge clk);
            g_re   = bus.glb_re;
            g_addr = bus.glb_r_addr;
            g_word = '0;
            for (int j = 0; j < 4; j++)
                if (g_re[j]) g_word[8*j +: 8] = mbyte(g_addr + 32'(j));
            #1 bus.glb_dout = g_word;
        end
    end

    // Monitor and scoreboard pop, sampled on the falling edge.
    initial begin
        done_cnt = 0; iss_cnt = 0; beats = 0; done_cyc = 0; last_hs_cyc = 0; last_keep = '0;
        forever begin
            @(negedge clk);
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (bus.glb_re != 4'b0000) iss_cnt++;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                beats++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    check("beat_data", bus.out_data, m_e.data);
                    check("beat_keep", bus.out_keep, m_e.keep);
                    check("beat_last", bus.out_last, m_e.last);
                end
                if (bus.out_last) begin
                    last_keep   = bus.out_keep;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] len);
        beat_t e;
        int rem, n;
        logic [31:0] a;
        rem = int'(len);
        a   = base;
        while (rem > 0) begin
            n = (rem >= 4) ? 4 : rem;
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < n; j++) begin
                e.keep[j] = 1'b1;
                e.data[8*j +: 8] = mbyte(a + 32'(j));
            end
            e.last = (rem <= 4);
            sb.push_back(e);
            a   = a + 32'd4;
            rem = rem - n;
        end
        last_keep     = '0;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.byte_len  = len;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input bit rnd);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 400) begin
            step();
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i++;
        end
        bus.out_ready = 1'b1;
        repeat (3) step();
        check({name, "_done_once"}, 128'(done_cnt - d0), 1);
        check({name, "_sb_empty"}, 128'(sb.size()), 0);
    endtask

    vec_t vt[7];

    initial begin
        int d0, b0, i0;
        n_pass = 0; n_total = 0;
        vt[0] = '{32'h0000_0100, 16'd8,  1'b0, 2,  4'b1111, 4'b1111};
        vt[1] = '{32'h0000_0200, 16'd7,  1'b0, 2,  4'b1111, 4'b0111};
        vt[2] = '{32'h0000_0300, 16'd1,  1'b0, 1,  4'b0001, 4'b0001};
        vt[3] = '{32'h0000_0405, 16'd3,  1'b1, 1,  4'b0111, 4'b0111};
        vt[4] = '{32'h0000_0500, 16'd13, 1'b1, 4,  4'b1111, 4'b0001};
        vt[5] = '{32'hFFFF_FFF8, 16'd12, 1'b0, 3,  4'b1111, 4'b1111};
        vt[6] = '{32'h0000_0600, 16'd40, 1'b1, 10, 4'b1111, 4'b1111};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.byte_len = '0; bus.out_ready = 1'b1;
        repeat (3) step();
        check("reset_outputs", {bus.busy, bus.done, bus.glb_re, bus.glb_r_addr, bus.out_valid,
                                bus.out_data, bus.out_keep, bus.out_last}, 0);
        rst_n = 1'b1;
        step();

        // Latency and done timing for the basic 8-byte transfer.
        d0 = done_cnt; b0 = beats;
        do_start(32'h100, 16'd8);
        @(negedge clk);
        check("t1_re0", {bus.glb_re, bus.glb_r_addr, bus.busy}, {4'b1111, 32'h100, 1'b1});
        step(); @(negedge clk);
        check("t1_re1", {bus.glb_re, bus.glb_r_addr}, {4'b1111, 32'h104});
        step(); @(negedge clk);
        check("t1_valid_c3", bus.out_valid, 1'b1);
        wait_done("t1", d0, 1'b0);
        check("t1_beats", 128'(beats - b0), 2);
        check("t1_done_lag", 128'(done_cyc - last_hs_cyc), 1);
        check("t1_busy_after", bus.busy, 1'b0);

        foreach (vt[k]) begin
            d0 = done_cnt; b0 = beats;
            do_start(vt[k].base, vt[k].len);
            @(negedge clk);
            check($sformatf("vec%0d_first_re", k), bus.glb_re, vt[k].exp_first_re);
            wait_done($sformatf("vec%0d", k), d0, vt[k].rnd);
            check($sformatf("vec%0d_beats", k), 128'(beats - b0), 128'(vt[k].exp_beats));
            check($sformatf("vec%0d_last_keep", k), last_keep, vt[k].exp_last_keep);
        end

        // Zero length: done next cycle, no read, no beat.
        d0 = done_cnt; b0 = beats; i0 = iss_cnt;
        do_start(32'h700, 16'd0);
        @(negedge clk);
        check("t3_done_c1", {bus.done, bus.glb_re, bus.busy}, {1'b1, 4'b0000, 1'b0});
        repeat (5) step();
        check("t3_no_issue", 128'(iss_cnt - i0), 0);
        check("t3_no_beat", 128'(beats - b0), 0);
        check("t3_done_once", 128'(done_cnt - d0), 1);

        // Backpressure: issue plateaus at FIFO depth, then everything drains in order.
        d0 = done_cnt; b0 = beats; i0 = iss_cnt;
        bus.out_ready = 1'b0;
        do_start(32'h1000, 16'd64);
        repeat (20) step();
        check("t4_plateau", 128'(iss_cnt - i0), 4);
        check("t4_valid_held", {bus.out_valid, bus.out_keep}, {1'b1, 4'b1111});
        wait_done("t4", d0, 1'b0);
        check("t4_beats", 128'(beats - b0), 16);

        // Start strobes while busy are ignored.
        d0 = done_cnt; b0 = beats;
        do_start(32'h2000, 16'd16);
        step();
        bus.start = 1'b1; bus.base_addr = 32'h9000; bus.byte_len = 16'd8;
        step();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("t5", d0, 1'b0);
        check("t5_beats", 128'(beats - b0), 4);

        // Asynchronous reset with beats queued, then a clean restart.
        bus.out_ready = 1'b0;
        do_start(32'h3000, 16'd32);
        repeat (3) step();
        check("t6_pre_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {bus.busy, bus.done, bus.glb_re, bus.glb_r_addr, bus.out_valid,
                                   bus.out_data, bus.out_keep, bus.out_last}, 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        d0 = done_cnt; b0 = beats;
        do_start(32'h100, 16'd8);
        @(negedge clk);
        check("t6_re0", {bus.glb_re, bus.glb_r_addr}, {4'b1111, 32'h100});
        wait_done("t6", d0, 1'b0);
        check("t6_beats", 128'(beats - b0), 2);
        check("t6_last_keep", last_keep, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
